instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, the fetch address after reset.
REQ-002 Parameter TIMEOUT, default 15, the number of REQ cycles without imem_rdy before fetch_err pulses.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstIn  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  16  word address of the current request.
REQ-007 imem_rdy  input  1  memory returns imem_data this cycle.
REQ-008 imem_data  input  32  instruction word from memory.
REQ-009 iw  output  32  instruction register.
REQ-010 IW2Contr  output  7  opcode field iw[31:25] for the controller.
REQ-011 pcOut  output  16  address that iw was fetched from.
REQ-012 iw_valid  output  1  iw/IW2Contr/pcOut are valid and held.
REQ-013 iw_ack  input  1  consumer accepts iw this cycle.
REQ-014 redirect  input  1  jump/call taken; flush and refetch.
REQ-015 redirect_pc  input  16  target address for redirect.
REQ-016 fetch_err  output  1  one-cycle pulse on request timeout.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ, HOLD.
REQ-018 IDLE SHALL go to REQ on the next edge.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal fetch_pc; in all other states imem_req SHALL be 0.
REQ-020 In REQ with imem_rdy=1 at an edge, these updates SHALL happen together: iw<=imem_data, pcOut<=fetch_pc, fetch_pc<=fetch_pc+1 (16-bit, 16'hFFFF wraps to 16'h0000), state->HOLD.
REQ-021 iw_valid SHALL be 1 exactly when state is HOLD.
REQ-022 With zero-wait memory (imem_rdy=1 throughout), iw_valid SHALL rise one cycle after imem_req rises.
REQ-023 In HOLD, iw, IW2Contr and pcOut SHALL stay stable until iw_ack=1; iw_ack SHALL move the state to REQ.
REQ-024 iw_ack outside HOLD SHALL be ignored.
REQ-025 IW2Contr SHALL always equal iw[31:25] (combinational from iw); it SHALL keep its last value while iw_valid=0.
REQ-026 redirect=1 SHALL take priority in every state: fetch_pc<=redirect_pc, state->REQ, wait counter cleared.
REQ-027 An imem_rdy coincident with redirect SHALL be discarded: iw and pcOut are unchanged.
REQ-028 redirect together with iw_ack in HOLD SHALL behave as redirect only; the held instruction counts as consumed.
REQ-029 The wait counter (4 bits minimum) SHALL count REQ cycles with imem_rdy=0 and clear on leaving REQ or on imem_rdy.
REQ-030 When the wait counter reaches TIMEOUT, fetch_err SHALL pulse high for one cycle and the counter SHALL clear; the state SHALL stay REQ with the same fetch_pc (retry).
REQ-031 imem_rdy outside REQ SHALL be ignored.

Reset
REQ-032 While rstIn=1, regardless of clk: state=IDLE, fetch_pc=RESET_PC, iw=0, IW2Contr=0, pcOut=RESET_PC, iw_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_err=0, wait counter=0.
REQ-033 Reset asserted mid-fetch or mid-HOLD SHALL abandon the transaction immediately, with no partial iw update.
REQ-034 The first request after reset release SHALL be at RESET_PC, issued one edge after release (IDLE->REQ).

Verification
REQ-035 Reset release, imem_rdy tied 1, memory word N = {7'(N),25'h0}, iw_ack tied 1 -> imem_addr 0,1,2,...; pcOut sequence 0,1,2; IW2Contr 0,1,2.
REQ-036 In HOLD with iw=32'h0400_0000, hold iw_ack=0 for 5 cycles -> iw_valid=1, IW2Contr=7'b0000010 stable, imem_req=0 throughout.
REQ-037 imem_rdy held 0 in REQ at addr 16'h0005 -> fetch_err pulses after 15 wait cycles, imem_addr stays 16'h0005; imem_rdy then 1 -> iw_valid=1, pcOut=16'h0005.
REQ-038 redirect=1, redirect_pc=16'h0040, in the same cycle as imem_rdy=1 -> data discarded; the next request is at 16'h0040; after the response, pcOut=16'h0040.
REQ-039 fetch_pc=16'hFFFF, zero-wait memory -> pcOut=16'hFFFF, then the next imem_addr=16'h0000.
REQ-040 rstIn pulsed asynchronously mid-HOLD -> iw_valid=0, iw=0, imem_req=0 immediately; after release, the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads to instruction memory, holds the
// fetched word until the consumer acknowledges it, and handles redirects and request timeouts.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rstIn,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_data,
  output logic [31:0] iw,
  output logic [6:0]  IW2Contr,
  output logic [15:0] pcOut,
  output logic        iw_valid,
  input  logic        iw_ack,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        fetch_err
);

  localparam int WCW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]     state;
  logic [15:0]    fetch_pc;
  logic [WCW-1:0] wcnt;
  logic           wait_expired;

  assign wait_expired = (int'(wcnt) + 1) >= int'(TIMEOUT);

  // Redirect overrides every state; any response arriving with it is dropped.
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      iw        <= '0;
      pcOut     <= RESET_PC;
      wcnt      <= '0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        state    <= REQ;
        wcnt     <= '0;
      end else begin
        case (state)
          IDLE: state <= REQ;
          REQ: begin
            if (imem_rdy) begin
              iw       <= imem_data;
              pcOut    <= fetch_pc;
              fetch_pc <= fetch_pc + 16'd1;
              state    <= HOLD;
              wcnt     <= '0;
            end else if (wait_expired) begin
              // Retry the same address after flagging the timeout.
              fetch_err <= 1'b1;
              wcnt      <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          HOLD: if (iw_ack) state <= REQ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = fetch_pc;
  assign iw_valid  = (state == HOLD);
  assign IW2Contr  = iw[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a transaction-level model predicts each
// delivered instruction into a scoreboard that an independent monitor drains.
module tb_instr_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rstIn = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] iw;
  logic [6:0]  IW2Contr;
  logic [15:0] pcOut;
  logic        iw_valid;
  logic        iw_ack = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        fetch_err;

  instr_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstIn(rstIn), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data), .iw(iw), .IW2Contr(IW2Contr),
    .pcOut(pcOut), .iw_valid(iw_valid), .iw_ack(iw_ack), .redirect(redirect),
    .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] w;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nmis = 0;

  // Reference model: what the fetch unit should be doing, expressed as a transaction-level view
  logic        exp_req = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_rst = 1'b1;
  logic [15:0] exp_pc = RESET_PC;
  int          wc = 0;
  logic        plain_mem = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (plain_mem) return {a[6:0], 25'h0};
    return {a[6:0] ^ a[15:9], a[8:0], a ^ 16'hC3A5};
  endfunction

  task automatic model_reset();
    exp_req   = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_pc    = RESET_PC;
    exp_rst   = 1'b1;
    wc        = 0;
    sbq.delete();
  endtask

  // One cycle: check the model against the DUT, drive new inputs, advance the model.
  task automatic step(input logic rst, input logic rdy, input logic ack,
                      input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("iw_valid", 32'(iw_valid), 32'(exp_valid));
    chk("fetch_err", 32'(fetch_err), 32'(exp_err));
    if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
    if (exp_rst) begin
      chk("rst_iw", iw, 32'h0);
      chk("rst_IW2Contr", 32'(IW2Contr), 32'h0);
      chk("rst_pcOut", 32'(pcOut), 32'(RESET_PC));
      chk("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC));
    end
    rstIn       = rst;
    imem_rdy    = rdy;
    iw_ack      = ack;
    redirect    = rd;
    redirect_pc = rpc;
    imem_data   = rdy ? mem_word(imem_addr) : $urandom();
    if (rst) begin
      model_reset();
    end else begin
      exp_rst = 1'b0;
      exp_err = 1'b0;
      if (rd) begin
        exp_pc = rpc; exp_req = 1'b1; exp_valid = 1'b0; wc = 0;
      end else if (exp_req) begin
        if (rdy) begin
          sbq.push_back('{pc: exp_pc, w: mem_word(exp_pc)});
          exp_pc = exp_pc + 16'd1;
          exp_req = 1'b0; exp_valid = 1'b1; wc = 0;
        end else begin
          wc++;
          if (wc == TIMEOUT) begin exp_err = 1'b1; wc = 0; end
        end
      end else if (exp_valid) begin
        if (ack) begin exp_valid = 1'b0; exp_req = 1'b1; end
      end else begin
        exp_req = 1'b1;
      end
    end
  endtask

  // Monitor: each new presentation pops one prediction; held words must not move.
  logic [31:0] held_iw = '0;
  logic [15:0] held_pc = '0;
  logic        prev_v = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstIn) begin
        prev_v = 1'b0;
      end else begin
        if (iw_valid && !prev_v) begin
          if (sbq.size() == 0) begin
            chk("spurious_iw", 32'(sbq.size()), 32'd1);
          end else begin
            e = sbq.pop_front();
            chk("iw", iw, e.w);
            chk("pcOut", 32'(pcOut), 32'(e.pc));
            chk("IW2Contr", 32'(IW2Contr), 32'(e.w[31:25]));
            held_iw = e.w;
            held_pc = e.pc;
          end
        end else if (iw_valid) begin
          chk("iw_held", iw, held_iw);
          chk("pcOut_held", 32'(pcOut), 32'(held_pc));
          chk("IW2Contr_held", 32'(IW2Contr), 32'(held_iw[31:25]));
        end
        prev_v = iw_valid;
      end
    end
  end

  initial begin
    int guard;
    logic rdy, ack, rd;

    // Reset held, then zero-wait sequential fetch with plain opcode words.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    guard = 0;
    while (!(exp_valid && exp_pc == 16'd3) && guard < 40) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      guard++;
    end
    if (guard >= 40) chk("reach_addr2_timeout", 32'(guard), 32'd0);

    // Hold the word from address 2 with no acknowledge.
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("hold_iw", iw, 32'h0400_0000);
    chk("hold_IW2Contr", 32'(IW2Contr), 32'h02);
    chk("hold_imem_req", 32'(imem_req), 32'd0);

    // Redirect to 5, then starve the request past the timeout.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
    repeat (17) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("retry_addr", 32'(imem_addr), 32'h0005);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("late_pcOut", 32'(pcOut), 32'h0005);

    // Response coincident with redirect is discarded.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("redir_pcOut", 32'(pcOut), 32'h0040);

    // Address wrap at the top of the space.
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);

    // Randomized traffic with scrambled memory contents and occasional starvation.
    plain_mem = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      rdy = ($urandom_range(99) < 70);
      ack = ($urandom_range(99) < 50);
      rd  = ($urandom_range(99) < 4);
      if ((i % 400) < 20) begin rdy = 1'b0; rd = 1'b0; end
      step(1'b0, rdy, ack, rd, 16'($urandom()));
    end

    // Asynchronous reset in the middle of a held instruction.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("pre_rst_valid", 32'(iw_valid), 32'd1);
    @(posedge clk);
    #2 rstIn = 1'b1;
    #1;
    chk("async_iw_valid", 32'(iw_valid), 32'd0);
    chk("async_iw", iw, 32'h0);
    chk("async_imem_req", 32'(imem_req), 32'd0);
    chk("async_pcOut", 32'(pcOut), 32'(RESET_PC));
    model_reset();
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);

    // Drain any outstanding prediction, then close out.
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
